// File: rtl/seq_scan_pkg.sv
// Shared types and defaults for the serial pattern scanner.
package seq_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    FIN  = 2'b10
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_PAT_W  = 5;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 5'b10010;

endpackage

// File: rtl/seq_window_cmp.sv
// PAT_W-bit shift window with saturating fill count; flags a hit when the
// window after the current shift is full and equals the pattern.
module seq_window_cmp
  import seq_scan_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic             clr_fill,
  output logic             hit
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  window;
  logic [PAT_W-1:0]  window_next;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_next;

  generate
    if (PAT_W == 1) begin : g_w1
      assign window_next = bit_in;
    end else begin : g_wn
      assign window_next = {window[PAT_W-2:0], bit_in};
    end
  endgenerate

  // Next fill level, saturating once the window holds PAT_W valid bits
  always_comb begin
    fill_next = fill;
    if (fill != FULL) fill_next = fill + FILL_W'(1);
  end

  assign hit = shift_en && (fill_next == FULL) && (window_next == pattern);

  // Window and fill registers; clr restarts both, clr_fill drops history after a hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window <= '0;
      fill   <= '0;
    end else if (clr) begin
      window <= '0;
      fill   <= '0;
    end else if (shift_en) begin
      window <= window_next;
      fill   <= clr_fill ? '0 : fill_next;
    end
  end

endmodule

// File: rtl/seq_scan_detector.sv
// Serial pattern detector: scans a latched word MSB-first, one bit per clock,
// reporting match presence, match count and position of the first match.
module seq_scan_detector
  import seq_scan_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int PAT_W      = DEF_PAT_W,
  parameter int OVERLAP    = 1,
  parameter int STOP_FIRST = 0,
  parameter int CNT_W      = $clog2(DATA_W + 1),
  parameter int POS_W      = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic [PAT_W-1:0]  pattern,
  output logic              busy,
  output logic              done,
  output logic              match,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [POS_W-1:0]  first_pos
);

  localparam logic [POS_W-1:0] LAST_IDX = POS_W'(DATA_W - 1);

  state_t state;
  state_t state_next;

  logic [DATA_W-1:0] data_sh;
  logic [PAT_W-1:0]  pattern_l;
  logic [POS_W-1:0]  idx;
  logic              load;
  logic              shift_en;
  logic              hit;
  logic              clr_fill;

  assign clr_fill = hit && (OVERLAP == 0);

  seq_window_cmp #(
    .PAT_W (PAT_W)
  ) u_window (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (load),
    .shift_en (shift_en),
    .bit_in   (data_sh[DATA_W-1]),
    .pattern  (pattern_l),
    .clr_fill (clr_fill),
    .hit      (hit)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state, load/consume strobes and status outputs; start always restarts
  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift_en   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        busy = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = SCAN;
        end else begin
          shift_en = 1'b1;
          if ((idx == LAST_IDX) || ((STOP_FIRST != 0) && hit)) state_next = FIN;
        end
      end
      FIN: begin
        done = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = SCAN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Latched operands and bit index; the word is held as a left-shifting copy
  // so the bit being consumed is always the MSB of data_sh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_sh   <= '0;
      pattern_l <= '0;
      idx       <= '0;
    end else if (load) begin
      data_sh   <= data;
      pattern_l <= pattern;
      idx       <= '0;
    end else if (shift_en) begin
      data_sh <= data_sh << 1;
      idx     <= idx + POS_W'(1);
    end
  end

  // Result registers, updated on the edge that consumes a hitting bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match     <= 1'b0;
      match_cnt <= '0;
      first_pos <= '0;
    end else if (load) begin
      match     <= 1'b0;
      match_cnt <= '0;
      first_pos <= '0;
    end else if (hit) begin
      match_cnt <= match_cnt + CNT_W'(1);
      if (!match) begin
        match     <= 1'b1;
        first_pos <= idx;
      end
    end
  end

endmodule

// File: tb/tb_seq_scan_detector.sv
// Bench for seq_scan_detector: three instances (overlap, non-overlap,
// stop-on-first) share stimulus and are checked against a positional model.
module tb_seq_scan_detector;

  localparam int DW = 8;
  localparam int PW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] data;
  logic [PW-1:0] pattern;

  logic       busy  [3];
  logic       done  [3];
  logic       match [3];
  logic [3:0] cnt   [3];
  logic [2:0] fpos  [3];

  int ov_cfg [3] = '{1, 0, 1};
  int sf_cfg [3] = '{0, 0, 1};

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_scan_detector #(.DATA_W(DW), .PAT_W(PW), .OVERLAP(1), .STOP_FIRST(0)) u_ov (
    .clk(clk), .rst_n(rst_n), .start(start), .data(data), .pattern(pattern),
    .busy(busy[0]), .done(done[0]), .match(match[0]), .match_cnt(cnt[0]), .first_pos(fpos[0]));

  seq_scan_detector #(.DATA_W(DW), .PAT_W(PW), .OVERLAP(0), .STOP_FIRST(0)) u_no (
    .clk(clk), .rst_n(rst_n), .start(start), .data(data), .pattern(pattern),
    .busy(busy[1]), .done(done[1]), .match(match[1]), .match_cnt(cnt[1]), .first_pos(fpos[1]));

  seq_scan_detector #(.DATA_W(DW), .PAT_W(PW), .OVERLAP(1), .STOP_FIRST(1)) u_sf (
    .clk(clk), .rst_n(rst_n), .start(start), .data(data), .pattern(pattern),
    .busy(busy[2]), .done(done[2]), .match(match[2]), .match_cnt(cnt[2]), .first_pos(fpos[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Slide a PW-wide window over the word by end position; a match ending at
  // i counts unless non-overlap mode and it shares bits with the last match.
  function automatic void model(input logic [DW-1:0] d, input logic [PW-1:0] p,
                                input int ov, input int sf,
                                output int e_cnt, output int e_pos, output int e_len);
    int last_end;
    bit ok;
    e_cnt = 0; e_pos = 0; e_len = DW; last_end = -1;
    for (int i = PW - 1; i < DW; i++) begin
      if (sf != 0 && e_cnt > 0) break;
      ok = 1'b1;
      for (int k = 0; k < PW; k++)
        if (d[DW-1-(i-PW+1+k)] != p[PW-1-k]) ok = 1'b0;
      if (ok && (ov != 0 || (i - PW + 1) > last_end)) begin
        e_cnt++;
        if (e_cnt == 1) e_pos = i;
        last_end = i;
        if (sf != 0) e_len = i + 1;
      end
    end
  endfunction

  // Called at a negedge; start is sampled on the following posedge
  task automatic start_pulse(input logic [DW-1:0] d, input logic [PW-1:0] p);
    data = d; pattern = p; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    data = DW'($urandom); pattern = PW'($urandom);
  endtask

  // n counts edges since the start edge; inputs are scrambled every cycle
  task automatic observe(input logic [DW-1:0] d, input logic [PW-1:0] p);
    int e_cnt, e_pos, e_len;
    int dcnt [3];
    int dcyc [3];
    int bcnt [3];
    logic       m_at [3];
    logic [3:0] c_at [3];
    logic [2:0] f_at [3];
    for (int k = 0; k < 3; k++) begin
      dcnt[k] = 0; dcyc[k] = -1; bcnt[k] = 0;
      m_at[k] = 1'b0; c_at[k] = '0; f_at[k] = '0;
    end
    for (int n = 0; n < DW + 3; n++) begin
      for (int k = 0; k < 3; k++) begin
        if (busy[k] === 1'b1) bcnt[k]++;
        if (done[k] === 1'b1) begin
          dcnt[k]++;
          if (dcyc[k] < 0) begin
            dcyc[k] = n; m_at[k] = match[k]; c_at[k] = cnt[k]; f_at[k] = fpos[k];
          end
        end
      end
      data = DW'($urandom); pattern = PW'($urandom);
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      model(d, p, ov_cfg[k], sf_cfg[k], e_cnt, e_pos, e_len);
      check($sformatf("u%0d d=%h p=%h done_pulses", k, d, p), dcnt[k], 1);
      check($sformatf("u%0d d=%h p=%h done_cycle", k, d, p), dcyc[k], e_len);
      check($sformatf("u%0d d=%h p=%h busy_cycles", k, d, p), bcnt[k], e_len);
      check($sformatf("u%0d d=%h p=%h match", k, d, p), m_at[k], (e_cnt > 0) ? 1 : 0);
      check($sformatf("u%0d d=%h p=%h match_cnt", k, d, p), c_at[k], e_cnt);
      check($sformatf("u%0d d=%h p=%h first_pos", k, d, p), f_at[k], e_pos);
      check($sformatf("u%0d d=%h p=%h cnt_held", k, d, p), cnt[k], e_cnt);
      check($sformatf("u%0d d=%h p=%h match_held", k, d, p), match[k], (e_cnt > 0) ? 1 : 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s u%0d busy", tag, k), busy[k], 0);
      check($sformatf("%s u%0d done", tag, k), done[k], 0);
      check($sformatf("%s u%0d match", tag, k), match[k], 0);
      check($sformatf("%s u%0d match_cnt", tag, k), cnt[k], 0);
      check($sformatf("%s u%0d first_pos", tag, k), fpos[k], 0);
    end
  endtask

  initial begin
    int early;
    logic [DW-1:0] d;
    logic [PW-1:0] p;
    int pos;

    rst_n = 1'b0; start = 1'b0; data = '0; pattern = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Reference word: overlap gives hits at 4 and 7, non-overlap only 4
    start_pulse(8'b10010010, 5'b10010);
    observe(8'b10010010, 5'b10010);

    start_pulse(8'h00, 5'b10010);
    observe(8'h00, 5'b10010);

    // Restart while idx 3 is next to be consumed
    start_pulse(8'b10010010, 5'b10010);
    early = 0;
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < 3; k++) if (done[k] === 1'b1) early++;
      if (n < 3) @(negedge clk);
    end
    check("abort_no_done", early, 0);
    start_pulse(8'b00010010, 5'b10010);
    observe(8'b00010010, 5'b10010);

    // Reset with idx 5 next to be consumed, after the first hit has landed
    start_pulse(8'b10010010, 5'b10010);
    repeat (5) @(negedge clk);
    check("pre_reset_match", match[0], 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midscan_reset");
    @(negedge clk);
    check_all_zero("held_reset");
    rst_n = 1'b1;
    @(negedge clk);
    start_pulse(8'b10010010, 5'b10010);
    observe(8'b10010010, 5'b10010);

    // Random words, about half with the pattern planted somewhere
    for (int i = 0; i < 40; i++) begin
      d = DW'($urandom);
      p = PW'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        pos = $urandom_range(0, DW - PW);
        d[DW-1-pos -: PW] = p;
      end
      start_pulse(d, p);
      observe(d, p);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
